ram_arbiter: RTL

//   Two-master arbiter in front of the single-port ram. Master 0 is the processor; master 1 is a

---
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/ram_arbiter.sv | 63 ++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two-master request/grant/read-return bus plus the shared ram port; lock lines exist only under ARB_LOCK_EN
interface ram_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
`ifdef ARB_LOCK_EN
  logic m0_lock, m1_lock;
`endif
  logic m0_req, m1_req;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [1:0] m0_ctrl, m1_ctrl;
  logic m0_gnt, m1_gnt;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic m0_rvalid, m1_rvalid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [1:0] ram_ctrl;
  logic [DATA_W-1:0] ram_rdata;
  modport slave (
`ifdef ARB_LOCK_EN
    input m0_lock, m1_lock,
`endif
    input m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_ctrl, m1_ctrl, ram_rdata,
    output m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid, ram_addr, ram_wdata, ram_ctrl
  );
  modport master (
`ifdef ARB_LOCK_EN
    output m0_lock, m1_lock,
`endif
    output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_ctrl, m1_ctrl, ram_rdata,
    input m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid, ram_addr, ram_wdata, ram_ctrl
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-master arbiter onto a single-port ram; ARB_LOCK_EN adds per-master lock for back-to-back accesses
module ram_arbiter #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int READ_LAT = 1
) (
  input logic clk,
  input logic reset,
  ram_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, RD0, RD1} state_t;
  state_t state;
  logic last_gnt, cur, acc, rd, last_cyc, relock, go, who;
  logic [2:0] cnt;
  logic [1:0] ctrl;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    cur = state == ACC1 || state == RD1;
    acc = state == ACC0 || state == ACC1;
    rd = state == RD0 || state == RD1;
    last_cyc = cnt == 3'(READ_LAT - 1);
`ifdef ARB_LOCK_EN
    relock = (acc && !bus.ram_ctrl[1] || rd && last_cyc) && (cur ? bus.m1_lock && bus.m1_req : bus.m0_lock && bus.m0_req);
`else
    relock = 1'b0;
`endif
    go = state == IDLE ? bus.m0_req || bus.m1_req : relock;
    who = state == IDLE ? bus.m1_req && (!bus.m0_req || !last_gnt) : cur;
    addr = who ? bus.m1_addr : bus.m0_addr;
    wdata = who ? bus.m1_wdata : bus.m0_wdata;
    ctrl = who ? bus.m1_ctrl : bus.m0_ctrl;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      cnt <= 3'd0;
      bus.m0_gnt <= 1'b0;
      bus.m1_gnt <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
      bus.ram_ctrl <= 2'b00;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
    end else begin
      bus.m0_gnt <= go && !who;
      bus.m1_gnt <= go && who;
      bus.m0_rvalid <= state == RD0 && last_cyc;
      bus.m1_rvalid <= state == RD1 && last_cyc;
      bus.m0_rdata <= state == RD0 && last_cyc ? bus.ram_rdata : bus.m0_rdata;
      bus.m1_rdata <= state == RD1 && last_cyc ? bus.ram_rdata : bus.m1_rdata;
      bus.ram_ctrl <= go ? {ctrl[1] && !ctrl[0], ctrl[0]} : 2'b00;
      bus.ram_addr <= go ? addr : bus.ram_addr;
      bus.ram_wdata <= go ? wdata : bus.ram_wdata;
      last_gnt <= acc ? cur : last_gnt;
      cnt <= rd ? cnt + 3'd1 : 3'd0;
      state <= go ? (who ? ACC1 : ACC0) : acc && bus.ram_ctrl[1] ? (cur ? RD1 : RD0) : rd && !last_cyc ? state : IDLE;
    end
  end
endmodule
